// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one memory port, one bus transaction at a time.
// Optional fetch starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_kill,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] bus_addr_q;
    logic [31:0] bus_wdata_q;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;
    logic        bus_we_q;
    logic        if_rvalid_q;
    logic        d_rvalid_q;
    logic        kill_q;
    logic        idle;
    logic        fetch_wins;
    logic        grant_if;
    logic        grant_d;

    // The starvation counter saturates at 7, so larger limits could never be reached.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
        $error("mem_port_arbiter: STARVE_LIMIT must be in 1..7");
    end

    assign idle = (state_q == IDLE);

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic [2:0] starve_q;

    assign fetch_wins = if_req && (!d_req || (starve_q >= LIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= 3'd0;
        end else if (grant_if) begin
            starve_q <= 3'd0;
        end else if (grant_d && if_req && (starve_q != 3'd7)) begin
            starve_q <= starve_q + 3'd1;
        end
    end
`else
    assign fetch_wins = if_req && !d_req;
`endif

    assign grant_if = !rst && idle && fetch_wins;
    assign grant_d  = !rst && idle && d_req && !fetch_wins;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            bus_we_q    <= 1'b0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            kill_q      <= 1'b0;
        end else begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        state_q     <= DATA;
                        bus_addr_q  <= d_addr;
                        bus_we_q    <= d_we;
                        bus_wdata_q <= d_wdata;
                        kill_q      <= 1'b0;
                    end else if (grant_if) begin
                        state_q     <= FETCH;
                        bus_addr_q  <= if_addr;
                        bus_we_q    <= 1'b0;
                        bus_wdata_q <= 32'd0;
                        kill_q      <= 1'b0;
                    end
                end
                FETCH: begin
                    // A kill in the ack cycle itself also drops the response.
                    if (bus_ack) begin
                        state_q <= IDLE;
                        if (!(kill_q || if_kill)) begin
                            if_rvalid_q <= 1'b1;
                            if_rdata_q  <= bus_rdata;
                        end
                    end else if (if_kill) begin
                        kill_q <= 1'b1;
                    end
                end
                DATA: begin
                    if (bus_ack) begin
                        state_q    <= IDLE;
                        d_rvalid_q <= 1'b1;
                        d_rdata_q  <= bus_we_q ? 32'd0 : bus_rdata;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A kill in the response cycle still suppresses the strobe.
    assign if_rvalid = if_rvalid_q && !if_kill;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign if_gnt    = grant_if;
    assign d_gnt     = grant_d;
    assign bus_req   = !idle;
    assign busy      = !idle;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

endmodule
